ysyx_22041071_id_stage: RTL and testbench

YSYX_22041071_ID_STAGE -- requirements
Module: ysyx_22041071_id_stage

---
 rtl/ysyx_22041071_id_stage_if.sv | 43 ++++
 rtl/ysyx_22041071_id_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_ysyx_22041071_id_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041071_id_stage_if.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_id_stage_if
// Handshake and bundle bus between the fetch stage, the decode stage and the
// execute stage.
//   slave  : the decode stage. It takes in_* / flush / out_ready and drives
//            in_ready plus the registered decoded bundle.
//   master : whatever surrounds the decode stage (fetch and execute, or a
//            testbench).
// Signals:
//   in_valid, in_ready, in_pc[XLEN], in_ins[32] : fetch -> decode handshake
//   flush                                       : redirect, kills held/incoming
//   out_valid, out_ready                        : decode -> execute handshake
//   out_pc, rs1, rs2, rd, imm, funct3, alu_op, ctrl : decoded bundle
// ---------------------------------------------------------------------------
interface ysyx_22041071_id_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_ins;
  logic            flush;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic [2:0]      funct3;
  logic [3:0]      alu_op;
  logic [7:0]      ctrl;

  modport master (
    output in_valid, in_pc, in_ins, flush, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, funct3, alu_op, ctrl
  );

  modport slave (
    input  in_valid, in_pc, in_ins, flush, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, funct3, alu_op, ctrl
  );
endinterface

// File: rtl/ysyx_22041071_id_stage.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_id_stage
// RV64I instruction decode stage: a single pipeline register. The decode of
// in_ins is purely combinational and is captured into the output registers
// when the instruction is accepted, giving one cycle of latency.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears every registered output
//   bus   : ysyx_22041071_id_stage_if.slave
//           in_valid/in_ready/in_pc/in_ins : incoming instruction handshake
//           flush                          : drop held and incoming instruction
//           out_valid/out_ready            : outgoing bundle handshake
//           out_pc, rs1, rs2, rd, imm, funct3, alu_op, ctrl : decoded bundle
//           ctrl = {illegal, jump, branch, mem_wen, mem_ren, reg_wen,
//                   is_word, use_imm}
// ---------------------------------------------------------------------------
module ysyx_22041071_id_stage #(
  parameter int XLEN = 64
) (
  input logic                       clk,
  input logic                       reset,
  ysyx_22041071_id_stage_if.slave   bus
);

  // Major opcodes
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_PCADD = 4'd11;

  localparam logic [31:0] INS_BUBBLE = 32'h0000_0000;
  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Map funct3 of an arithmetic instruction to an ALU code; alt selects
  // SUB over ADD and SRA over SRL.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Raw instruction fields
  logic [6:0]      opcode_s;
  logic [2:0]      f3_s;
  logic [6:0]      f7_s;
  logic [4:0]      rd_f_s;
  logic [4:0]      rs1_f_s;
  logic [4:0]      rs2_f_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_st_s;
  logic [XLEN-1:0] imm_b_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] imm_j_s;

  assign opcode_s = bus.in_ins[6:0];
  assign rd_f_s   = bus.in_ins[11:7];
  assign f3_s     = bus.in_ins[14:12];
  assign rs1_f_s  = bus.in_ins[19:15];
  assign rs2_f_s  = bus.in_ins[24:20];
  assign f7_s     = bus.in_ins[31:25];

  assign imm_i_s  = {{(XLEN-12){bus.in_ins[31]}}, bus.in_ins[31:20]};
  assign imm_st_s = {{(XLEN-12){bus.in_ins[31]}}, bus.in_ins[31:25], bus.in_ins[11:7]};
  assign imm_b_s  = {{(XLEN-13){bus.in_ins[31]}}, bus.in_ins[31], bus.in_ins[7],
                     bus.in_ins[30:25], bus.in_ins[11:8], 1'b0};
  assign imm_u_s  = {{(XLEN-32){bus.in_ins[31]}}, bus.in_ins[31:12], 12'h000};
  assign imm_j_s  = {{(XLEN-21){bus.in_ins[31]}}, bus.in_ins[31], bus.in_ins[19:12],
                     bus.in_ins[20], bus.in_ins[30:21], 1'b0};

  // Combinational decode results
  logic [4:0]      dec_rd_s;
  logic [4:0]      dec_rs1_s;
  logic [4:0]      dec_rs2_s;
  logic [XLEN-1:0] dec_imm_s;
  logic [2:0]      dec_funct3_s;
  logic [3:0]      dec_alu_s;
  logic [7:0]      dec_ctrl_s;
  logic            illegal_s;
  logic            jump_s;
  logic            branch_s;
  logic            mem_wen_s;
  logic            mem_ren_s;
  logic            reg_wen_raw_s;
  logic            is_word_s;
  logic            use_imm_s;

  // Handshake
  logic in_ready_s;
  logic accept_s;

  // Output registers
  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [4:0]      rs1_r;
  logic [4:0]      rs2_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] imm_r;
  logic [2:0]      funct3_r;
  logic [3:0]      alu_r;
  logic [7:0]      ctrl_r;

  // Instruction decode: fields, immediate, ALU op, control bits, legality
  always_comb begin
    dec_rd_s      = 5'd0;
    dec_rs1_s     = 5'd0;
    dec_rs2_s     = 5'd0;
    dec_imm_s     = {XLEN{1'b0}};
    dec_funct3_s  = 3'd0;
    dec_alu_s     = ALU_ADD;
    dec_ctrl_s    = 8'h00;
    illegal_s     = 1'b0;
    jump_s        = 1'b0;
    branch_s      = 1'b0;
    mem_wen_s     = 1'b0;
    mem_ren_s     = 1'b0;
    reg_wen_raw_s = 1'b0;
    is_word_s     = 1'b0;
    use_imm_s     = 1'b0;

    if (bus.in_ins != INS_BUBBLE) begin
      case (opcode_s)
        OPC_LUI: begin
          dec_rd_s      = rd_f_s;
          dec_imm_s     = imm_u_s;
          dec_alu_s     = ALU_LUI;
          reg_wen_raw_s = 1'b1;
          use_imm_s     = 1'b1;
        end
        OPC_AUIPC: begin
          dec_rd_s      = rd_f_s;
          dec_imm_s     = imm_u_s;
          dec_alu_s     = ALU_PCADD;
          reg_wen_raw_s = 1'b1;
          use_imm_s     = 1'b1;
        end
        OPC_JAL: begin
          dec_rd_s      = rd_f_s;
          dec_imm_s     = imm_j_s;
          dec_alu_s     = ALU_PCADD;
          jump_s        = 1'b1;
          reg_wen_raw_s = 1'b1;
          use_imm_s     = 1'b1;
        end
        OPC_JALR: begin
          dec_rd_s      = rd_f_s;
          dec_rs1_s     = rs1_f_s;
          dec_imm_s     = imm_i_s;
          dec_funct3_s  = f3_s;
          jump_s        = 1'b1;
          reg_wen_raw_s = 1'b1;
          use_imm_s     = 1'b1;
          illegal_s     = (f3_s != 3'b000);
        end
        OPC_BRANCH: begin
          dec_rs1_s    = rs1_f_s;
          dec_rs2_s    = rs2_f_s;
          dec_imm_s    = imm_b_s;
          dec_funct3_s = f3_s;
          dec_alu_s    = ALU_SUB;
          branch_s     = 1'b1;
          // funct3 010/011 are unassigned branch conditions
          illegal_s    = (f3_s[2:1] == 2'b01);
        end
        OPC_LOAD: begin
          dec_rd_s      = rd_f_s;
          dec_rs1_s     = rs1_f_s;
          dec_imm_s     = imm_i_s;
          dec_funct3_s  = f3_s;
          mem_ren_s     = 1'b1;
          reg_wen_raw_s = 1'b1;
          use_imm_s     = 1'b1;
          illegal_s     = (f3_s == 3'b111);
        end
        OPC_STORE: begin
          dec_rs1_s    = rs1_f_s;
          dec_rs2_s    = rs2_f_s;
          dec_imm_s    = imm_st_s;
          dec_funct3_s = f3_s;
          mem_wen_s    = 1'b1;
          use_imm_s    = 1'b1;
          illegal_s    = f3_s[2];
        end
        OPC_OP_IMM: begin
          dec_rd_s      = rd_f_s;
          dec_rs1_s     = rs1_f_s;
          dec_imm_s     = imm_i_s;
          dec_funct3_s  = f3_s;
          dec_alu_s     = alu_sel(f3_s, (f3_s == 3'b101) && bus.in_ins[30]);
          reg_wen_raw_s = 1'b1;
          use_imm_s     = 1'b1;
          // 64-bit shifts use a 6-bit shamt, so only ins[31:26] is funct
          case (f3_s)
            3'b001:  illegal_s = (bus.in_ins[31:26] != 6'b000000);
            3'b101:  illegal_s = (bus.in_ins[31:26] != 6'b000000) &&
                                 (bus.in_ins[31:26] != 6'b010000);
            default: illegal_s = 1'b0;
          endcase
        end
        OPC_OP_IMM32: begin
          dec_rd_s      = rd_f_s;
          dec_rs1_s     = rs1_f_s;
          dec_imm_s     = imm_i_s;
          dec_funct3_s  = f3_s;
          dec_alu_s     = alu_sel(f3_s, (f3_s == 3'b101) && bus.in_ins[30]);
          reg_wen_raw_s = 1'b1;
          is_word_s     = 1'b1;
          use_imm_s     = 1'b1;
          case (f3_s)
            3'b000:  illegal_s = 1'b0;
            3'b001:  illegal_s = (f7_s != F7_ZERO);
            3'b101:  illegal_s = (f7_s != F7_ZERO) && (f7_s != F7_ALT);
            default: illegal_s = 1'b1;
          endcase
        end
        OPC_OP: begin
          dec_rd_s      = rd_f_s;
          dec_rs1_s     = rs1_f_s;
          dec_rs2_s     = rs2_f_s;
          dec_funct3_s  = f3_s;
          dec_alu_s     = alu_sel(f3_s, f7_s == F7_ALT);
          reg_wen_raw_s = 1'b1;
          // funct7 0100000 only exists for SUB and SRA
          illegal_s     = !((f7_s == F7_ZERO) ||
                            ((f7_s == F7_ALT) && ((f3_s == 3'b000) || (f3_s == 3'b101))));
        end
        OPC_OP32: begin
          dec_rd_s      = rd_f_s;
          dec_rs1_s     = rs1_f_s;
          dec_rs2_s     = rs2_f_s;
          dec_funct3_s  = f3_s;
          dec_alu_s     = alu_sel(f3_s, f7_s == F7_ALT);
          reg_wen_raw_s = 1'b1;
          is_word_s     = 1'b1;
          case (f3_s)
            3'b000:  illegal_s = (f7_s != F7_ZERO) && (f7_s != F7_ALT);
            3'b001:  illegal_s = (f7_s != F7_ZERO);
            3'b101:  illegal_s = (f7_s != F7_ZERO) && (f7_s != F7_ALT);
            default: illegal_s = 1'b1;
          endcase
        end
        OPC_MISC_MEM: begin
          // FENCE has no architectural effect in this in-order pipe
          illegal_s = (f3_s != 3'b000);
        end
        OPC_SYSTEM: begin
          illegal_s = (bus.in_ins != INS_ECALL) && (bus.in_ins != INS_EBREAK);
        end
        default: begin
          illegal_s = 1'b1;
        end
      endcase
    end else begin
      // Fetch bubble: everything stays at its zero default
      illegal_s = 1'b0;
    end

    // An illegal instruction carries nothing but the illegal flag
    if (illegal_s) begin
      dec_rd_s     = 5'd0;
      dec_rs1_s    = 5'd0;
      dec_rs2_s    = 5'd0;
      dec_imm_s    = {XLEN{1'b0}};
      dec_funct3_s = 3'd0;
      dec_alu_s    = ALU_ADD;
      dec_ctrl_s   = 8'h80;
    end else begin
      dec_ctrl_s = {1'b0, jump_s, branch_s, mem_wen_s, mem_ren_s,
                    reg_wen_raw_s & (dec_rd_s != 5'd0), is_word_s, use_imm_s};
    end
  end

  // Ready whenever the register is empty or being drained this cycle
  assign in_ready_s = bus.out_ready | ~valid_r;
  assign accept_s   = bus.in_valid & in_ready_s & ~bus.flush;

  // Pipeline register: reset, then flush, then accept, then drain, else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r  <= 1'b0;
      pc_r     <= {XLEN{1'b0}};
      rs1_r    <= 5'd0;
      rs2_r    <= 5'd0;
      rd_r     <= 5'd0;
      imm_r    <= {XLEN{1'b0}};
      funct3_r <= 3'd0;
      alu_r    <= 4'd0;
      ctrl_r   <= 8'h00;
    end else if (bus.flush) begin
      valid_r <= 1'b0;
    end else if (accept_s) begin
      valid_r  <= 1'b1;
      pc_r     <= bus.in_pc;
      rs1_r    <= dec_rs1_s;
      rs2_r    <= dec_rs2_s;
      rd_r     <= dec_rd_s;
      imm_r    <= dec_imm_s;
      funct3_r <= dec_funct3_s;
      alu_r    <= dec_alu_s;
      ctrl_r   <= dec_ctrl_s;
    end else if (valid_r && bus.out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_r;
  assign bus.out_pc    = pc_r;
  assign bus.rs1       = rs1_r;
  assign bus.rs2       = rs2_r;
  assign bus.rd        = rd_r;
  assign bus.imm       = imm_r;
  assign bus.funct3    = funct3_r;
  assign bus.alu_op    = alu_r;
  assign bus.ctrl      = ctrl_r;

endmodule

// File: tb/tb_ysyx_22041071_id_stage.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041071_id_stage
// Directed bench for the decode stage. Inputs are driven 1 time unit after a
// rising edge and outputs are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_ysyx_22041071_id_stage;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ysyx_22041071_id_stage_if #(.XLEN(64)) bus ();

  ysyx_22041071_id_stage #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bit positions inside ctrl
  localparam logic [7:0] C_ILLEGAL = 8'h80;
  localparam logic [7:0] C_JUMP    = 8'h40;
  localparam logic [7:0] C_BRANCH  = 8'h20;
  localparam logic [7:0] C_MEM_WEN = 8'h10;
  localparam logic [7:0] C_MEM_REN = 8'h08;
  localparam logic [7:0] C_REG_WEN = 8'h04;
  localparam logic [7:0] C_IS_WORD = 8'h02;
  localparam logic [7:0] C_USE_IMM = 8'h01;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] pc, input logic [31:0] ins);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_ins   = ins;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pc     = 64'h0;
    bus.in_ins    = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("rst_out_pc",    bus.out_pc, 64'h0);
    chk("rst_imm",       bus.imm, 64'h0);
    chk("rst_ctrl",      {56'h0, bus.ctrl}, 64'h0);
    chk("rst_in_ready",  {63'h0, bus.in_ready}, 64'h1);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'h0, bus.in_ready}, 64'h1);

    // addi x1,x0,5
    send(64'h0000_0000_8000_0000, 32'h0050_0093);
    chk("addi_valid",  {63'h0, bus.out_valid}, 64'h1);
    chk("addi_pc",     bus.out_pc, 64'h0000_0000_8000_0000);
    chk("addi_rd",     {59'h0, bus.rd}, 64'd1);
    chk("addi_rs1",    {59'h0, bus.rs1}, 64'd0);
    chk("addi_imm",    bus.imm, 64'd5);
    chk("addi_alu",    {60'h0, bus.alu_op}, 64'd0);
    chk("addi_ctrl",   {56'h0, bus.ctrl}, {56'h0, C_REG_WEN | C_USE_IMM});

    // sw x1,-4(x2)
    send(64'h0000_0000_8000_0004, 32'hFE11_2E23);
    chk("sw_rs1",    {59'h0, bus.rs1}, 64'd2);
    chk("sw_rs2",    {59'h0, bus.rs2}, 64'd1);
    chk("sw_imm",    bus.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sw_funct3", {61'h0, bus.funct3}, 64'd2);
    chk("sw_alu",    {60'h0, bus.alu_op}, 64'd0);
    chk("sw_ctrl",   {56'h0, bus.ctrl}, {56'h0, C_MEM_WEN | C_USE_IMM});

    // beq x0,x0,-8
    send(64'h0000_0000_8000_0008, 32'hFE00_0CE3);
    chk("beq_imm",  bus.imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_alu",  {60'h0, bus.alu_op}, 64'd1);
    chk("beq_ctrl", {56'h0, bus.ctrl}, {56'h0, C_BRANCH});

    // Stall three cycles with a new instruction waiting
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h0000_0000_8000_000C;
    bus.in_ins    = 32'h0050_0193;
    #1;
    chk("stall_in_ready0", {63'h0, bus.in_ready}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid",    {63'h0, bus.out_valid}, 64'h1);
      chk("stall_pc",       bus.out_pc, 64'h0000_0000_8000_0008);
      chk("stall_imm",      bus.imm, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("stall_ctrl",     {56'h0, bus.ctrl}, {56'h0, C_BRANCH});
      chk("stall_in_ready", {63'h0, bus.in_ready}, 64'h0);
    end

    // Release: addi x3,x0,5 is accepted
    bus.out_ready = 1'b1;
    tick();
    chk("release_valid", {63'h0, bus.out_valid}, 64'h1);
    chk("release_rd",    {59'h0, bus.rd}, 64'd3);
    chk("release_pc",    bus.out_pc, 64'h0000_0000_8000_000C);

    // Flush beats a simultaneous acceptance; in_ready not gated by flush
    bus.flush  = 1'b1;
    bus.in_pc  = 64'h0000_0000_8000_0010;
    bus.in_ins = 32'h0050_0213;
    #1;
    chk("flush_in_ready", {63'h0, bus.in_ready}, 64'h1);
    tick();
    chk("flush_valid", {63'h0, bus.out_valid}, 64'h0);
    bus.flush = 1'b0;

    // Bubble
    send(64'h0000_0000_8000_0020, 32'h0000_0000);
    chk("bubble_valid", {63'h0, bus.out_valid}, 64'h1);
    chk("bubble_ctrl",  {56'h0, bus.ctrl}, 64'h0);
    chk("bubble_alu",   {60'h0, bus.alu_op}, 64'h0);
    chk("bubble_imm",   bus.imm, 64'h0);
    chk("bubble_rd",    {59'h0, bus.rd}, 64'h0);

    // Drain with nothing incoming: valid drops, bundle holds
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("drain_pc",    bus.out_pc, 64'h0000_0000_8000_0020);

    // All-ones word is illegal
    send(64'h0000_0000_8000_0024, 32'hFFFF_FFFF);
    chk("ones_ctrl", {56'h0, bus.ctrl}, {56'h0, C_ILLEGAL});

    // addi x0,x0,1: no register write
    send(64'h0000_0000_8000_0028, 32'h0010_0013);
    chk("x0_ctrl", {56'h0, bus.ctrl}, {56'h0, C_USE_IMM});

    // ebreak
    send(64'h0000_0000_8000_002C, 32'h0010_0073);
    chk("ebreak_ctrl",   {56'h0, bus.ctrl}, 64'h0);
    chk("ebreak_funct3", {61'h0, bus.funct3}, 64'h0);

    // mul x1,x2,x3 is outside RV64I
    send(64'h0000_0000_8000_0030, 32'h0231_00B3);
    chk("mul_ctrl", {56'h0, bus.ctrl}, {56'h0, C_ILLEGAL});

    // sub x5,x6,x7
    send(64'h0000_0000_8000_0034, 32'h4073_02B3);
    chk("sub_alu",  {60'h0, bus.alu_op}, 64'd1);
    chk("sub_ctrl", {56'h0, bus.ctrl}, {56'h0, C_REG_WEN});
    chk("sub_rs2",  {59'h0, bus.rs2}, 64'd7);
    chk("sub_imm",  bus.imm, 64'h0);

    // lui x1,0x12345
    send(64'h0000_0000_8000_0038, 32'h1234_50B7);
    chk("lui_imm",  bus.imm, 64'h0000_0000_1234_5000);
    chk("lui_alu",  {60'h0, bus.alu_op}, 64'd10);
    chk("lui_ctrl", {56'h0, bus.ctrl}, {56'h0, C_REG_WEN | C_USE_IMM});

    // jal x1,-4
    send(64'h0000_0000_8000_003C, 32'hFFDF_F0EF);
    chk("jal_imm",  bus.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal_alu",  {60'h0, bus.alu_op}, 64'd11);
    chk("jal_ctrl", {56'h0, bus.ctrl}, {56'h0, C_JUMP | C_REG_WEN | C_USE_IMM});

    // sraiw x2,x2,3
    send(64'h0000_0000_8000_0040, 32'h4031_511B);
    chk("sraiw_alu",  {60'h0, bus.alu_op}, 64'd7);
    chk("sraiw_ctrl", {56'h0, bus.ctrl}, {56'h0, C_REG_WEN | C_IS_WORD | C_USE_IMM});

    // ld x5,8(x1)
    send(64'h0000_0000_8000_0044, 32'h0080_B283);
    chk("ld_imm",    bus.imm, 64'd8);
    chk("ld_funct3", {61'h0, bus.funct3}, 64'd3);
    chk("ld_ctrl",   {56'h0, bus.ctrl}, {56'h0, C_MEM_REN | C_REG_WEN | C_USE_IMM});

    // Reset while stalled with a valid bundle
    bus.out_ready = 1'b0;
    send(64'h0000_0000_8000_0048, 32'h0050_0093);
    chk("pre_rst_valid", {63'h0, bus.out_valid}, 64'h1);
    reset = 1'b1;
    tick();
    chk("rst2_valid",    {63'h0, bus.out_valid}, 64'h0);
    chk("rst2_pc",       bus.out_pc, 64'h0);
    chk("rst2_rd",       {59'h0, bus.rd}, 64'h0);
    chk("rst2_rs1",      {59'h0, bus.rs1}, 64'h0);
    chk("rst2_imm",      bus.imm, 64'h0);
    chk("rst2_alu",      {60'h0, bus.alu_op}, 64'h0);
    chk("rst2_ctrl",     {56'h0, bus.ctrl}, 64'h0);
    chk("rst2_in_ready", {63'h0, bus.in_ready}, 64'h1);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
